// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one memory/I/O bus among MASTERS requesters.
// Requests and grants are active low. Grants are registered and one-hot.
// A configurable idle gap separates successive owners so that bus drivers
// never overlap. Tenure is only monitored (tenure_ovf) and never revoked.
module bus_arbiter #(
   parameter int MASTERS     = 2,
   parameter int RR_MODE     = 1,
   parameter int TURN_CYCLES = 1,
   parameter int MAX_TENURE  = 64,
   parameter int OW          = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [MASTERS-1:0] breq_,
   output logic [MASTERS-1:0] bgrt_,
   output logic [OW-1:0]      owner,
   output logic               bus_busy,
   output logic               tenure_ovf
);

   localparam int NP = 1 << OW;
   localparam int TW = (MAX_TENURE < 1) ? 1 : $clog2(MAX_TENURE + 1);
   localparam logic [TW-1:0]      MAX_T     = TW'(MAX_TENURE);
   localparam logic [2:0]         TURN_LOAD = (TURN_CYCLES > 0) ? 3'(TURN_CYCLES - 1) : 3'd0;
   localparam logic [OW-1:0]      LAST_IDX  = OW'(MASTERS - 1);
   localparam logic [MASTERS-1:0] ONE_HOT0  = MASTERS'(1);
   localparam logic               OVF_EN    = (MAX_TENURE != 0);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } state_t;

   state_t             state_r, state_n;
   logic [MASTERS-1:0] bgrt_r, bgrt_n;
   logic [OW-1:0]      owner_r, owner_n;
   logic               busy_r, busy_n;
   logic               ovf_r, ovf_n;
   logic [OW-1:0]      rr_ptr_r, rr_ptr_n;
   logic [2:0]         turn_cnt_r, turn_n;
   logic [TW-1:0]      tenure_cnt_r, tenure_n;

   logic [NP-1:0]      req_pad_s;
   logic [OW-1:0]      ptr_sel_s;
   logic [OW:0]        pick_s;
   logic [OW-1:0]      next_ptr_s;

   // Returns {found, index}: first active request at or above ptr, wrapping
   // modulo MASTERS. Scanning from the far end lets the nearest hit win.
   function automatic logic [OW:0] pick_winner(input logic [NP-1:0] req,
                                               input logic [OW-1:0] ptr);
      logic [OW:0] cand;
      logic [OW:0] result;
      result = '0;
      for (int i = MASTERS - 1; i >= 0; i--) begin
         cand = {1'b0, ptr} + (OW+1)'(i);
         if (cand >= (OW+1)'(MASTERS)) begin
            cand = cand - (OW+1)'(MASTERS);
         end else begin
            cand = cand;
         end
         if (req[cand[OW-1:0]]) begin
            result = {1'b1, cand[OW-1:0]};
         end else begin
            result = result;
         end
      end
      return result;
   endfunction

   // Active-high request vector padded to the full index space (padding never wins) and winner pick.
   always_comb begin
      req_pad_s                = '0;
      req_pad_s[MASTERS-1:0]   = ~breq_;
      ptr_sel_s                = '0;
      next_ptr_s               = '0;
      if (RR_MODE != 0) begin
         ptr_sel_s = rr_ptr_r;
      end else begin
         ptr_sel_s = '0;
      end
      pick_s = pick_winner(req_pad_s, ptr_sel_s);
      if (RR_MODE == 0) begin
         next_ptr_s = '0;
      end else if (pick_s[OW-1:0] == LAST_IDX) begin
         next_ptr_s = '0;
      end else begin
         next_ptr_s = pick_s[OW-1:0] + OW'(1);
      end
   end

   // Next-state, next-output and counter updates for the IDLE/GRANT/TURN sequence.
   always_comb begin
      state_n  = state_r;
      bgrt_n   = bgrt_r;
      owner_n  = owner_r;
      busy_n   = busy_r;
      ovf_n    = ovf_r;
      rr_ptr_n = rr_ptr_r;
      turn_n   = turn_cnt_r;
      tenure_n = tenure_cnt_r;
      case (state_r)
         IDLE: begin
            if (pick_s[OW]) begin
               state_n  = GRANT;
               bgrt_n   = ~(ONE_HOT0 << pick_s[OW-1:0]);
               owner_n  = pick_s[OW-1:0];
               busy_n   = 1'b1;
               ovf_n    = 1'b0;
               tenure_n = '0;
               rr_ptr_n = next_ptr_s;
            end else begin
               bgrt_n = '1;
               busy_n = 1'b0;
               ovf_n  = 1'b0;
            end
         end
         GRANT: begin
            if (req_pad_s[owner_r]) begin
               // Owner keeps the bus; other requests are ignored.
               if (tenure_cnt_r < MAX_T) begin
                  tenure_n = tenure_cnt_r + TW'(1);
               end else begin
                  tenure_n = tenure_cnt_r;
               end
               ovf_n = OVF_EN & (tenure_n >= MAX_T);
            end else begin
               // Release: owner index is kept, everything else goes idle.
               bgrt_n   = '1;
               busy_n   = 1'b0;
               ovf_n    = 1'b0;
               tenure_n = '0;
               if (TURN_CYCLES == 0) begin
                  state_n = IDLE;
               end else begin
                  state_n = TURN;
                  turn_n  = TURN_LOAD;
               end
            end
         end
         TURN: begin
            if (turn_cnt_r == 3'd0) begin
               state_n = IDLE;
            end else begin
               turn_n = turn_cnt_r - 3'd1;
            end
         end
         default: begin
            state_n  = IDLE;
            bgrt_n   = '1;
            busy_n   = 1'b0;
            ovf_n    = 1'b0;
            turn_n   = 3'd0;
            tenure_n = '0;
         end
      endcase
   end

   // State and registered outputs; reset drops any grant immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= IDLE;
         bgrt_r       <= '1;
         owner_r      <= '0;
         busy_r       <= 1'b0;
         ovf_r        <= 1'b0;
         rr_ptr_r     <= '0;
         turn_cnt_r   <= 3'd0;
         tenure_cnt_r <= '0;
      end else begin
         state_r      <= state_n;
         bgrt_r       <= bgrt_n;
         owner_r      <= owner_n;
         busy_r       <= busy_n;
         ovf_r        <= ovf_n;
         rr_ptr_r     <= rr_ptr_n;
         turn_cnt_r   <= turn_n;
         tenure_cnt_r <= tenure_n;
      end
   end

   assign bgrt_      = bgrt_r;
   assign owner      = owner_r;
   assign bus_busy   = busy_r;
   assign tenure_ovf = ovf_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: three arbiter configurations driven side by side and
// compared against a timestamp-based model of the ownership rules.
module tb_bus_arbiter;

   logic       clk;
   logic       reset;
   logic [7:0] rq [3];

   logic [1:0] bgrt_a, bgrt_b;
   logic [2:0] bgrt_c;
   logic [2:0] owner_a, owner_b;
   logic [1:0] owner_c;
   logic       busy_a, busy_b, busy_c;
   logic       ovf_a, ovf_b, ovf_c;

   int vectors;
   int miscompares;
   int edge_n;

   // Configuration of each instance: masters, round-robin, gap, tenure limit.
   int P_M  [3] = '{2, 2, 3};
   int P_RR [3] = '{1, 0, 1};
   int P_T  [3] = '{1, 0, 3};
   int P_X  [3] = '{4, 0, 6};

   // Model state: owner, busy flag, first edge a grant is allowed, grant edge, rr pointer.
   int m_busy [3];
   int m_own  [3];
   int m_free [3];
   int m_gedge[3];
   int m_ptr  [3];

   bus_arbiter #(.MASTERS(2), .RR_MODE(1), .TURN_CYCLES(1), .MAX_TENURE(4), .OW(3)) u_a (
      .clk(clk), .reset(reset), .breq_(rq[0][1:0]), .bgrt_(bgrt_a),
      .owner(owner_a), .bus_busy(busy_a), .tenure_ovf(ovf_a));

   bus_arbiter #(.MASTERS(2), .RR_MODE(0), .TURN_CYCLES(0), .MAX_TENURE(0), .OW(3)) u_b (
      .clk(clk), .reset(reset), .breq_(rq[1][1:0]), .bgrt_(bgrt_b),
      .owner(owner_b), .bus_busy(busy_b), .tenure_ovf(ovf_b));

   bus_arbiter #(.MASTERS(3), .RR_MODE(1), .TURN_CYCLES(3), .MAX_TENURE(6), .OW(2)) u_c (
      .clk(clk), .reset(reset), .breq_(rq[2][2:0]), .bgrt_(bgrt_c),
      .owner(owner_c), .bus_busy(busy_c), .tenure_ovf(ovf_c));

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Time limit so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, vectors=%0d", vectors);
      $fatal(1, "watchdog");
   end

   function automatic void model_reset();
      for (int k = 0; k < 3; k++) begin
         m_busy[k]  = 0;
         m_own[k]   = 0;
         m_free[k]  = 0;
         m_gedge[k] = 0;
         m_ptr[k]   = 0;
      end
   endfunction

   // Apply one clock edge of the ownership rules to every instance.
   function automatic void model_edge();
      for (int k = 0; k < 3; k++) begin
         int r;
         int base;
         int idx;
         r = int'(~rq[k]) & ((1 << P_M[k]) - 1);
         if (m_busy[k] != 0) begin
            if (((r >> m_own[k]) & 1) == 0) begin
               m_busy[k] = 0;
               m_free[k] = edge_n + P_T[k] + 1;
            end
         end else if (edge_n >= m_free[k] && r != 0) begin
            base = (P_RR[k] != 0) ? m_ptr[k] : 0;
            idx  = -1;
            for (int j = 0; j < P_M[k]; j++) begin
               int c;
               c = (base + j) % P_M[k];
               if (idx < 0 && ((r >> c) & 1) == 1) idx = c;
            end
            m_own[k]   = idx;
            m_busy[k]  = 1;
            m_gedge[k] = edge_n;
            m_ptr[k]   = (idx + 1) % P_M[k];
         end
      end
   endfunction

   // Expected {active-high grant, busy, owner, ovf} of instance k.
   function automatic logic [12:0] exp_vec(input int k);
      logic [7:0] g;
      logic       v;
      g = (m_busy[k] != 0) ? (8'd1 << m_own[k]) : 8'd0;
      v = (m_busy[k] != 0) && (P_X[k] != 0) && ((edge_n - m_gedge[k]) >= P_X[k]);
      return {g, (m_busy[k] != 0), 3'(m_own[k]), v};
   endfunction

   // Observed outputs of instance k in the same layout.
   function automatic logic [12:0] obs_vec(input int k);
      logic [7:0] g;
      logic       b;
      logic [2:0] o;
      logic       v;
      case (k)
         0: begin g = {6'd0, ~bgrt_a}; b = busy_a; o = owner_a; v = ovf_a; end
         1: begin g = {6'd0, ~bgrt_b}; b = busy_b; o = owner_b; v = ovf_b; end
         default: begin g = {5'd0, ~bgrt_c}; b = busy_c; o = {1'b0, owner_c}; v = ovf_c; end
      endcase
      return {g, b, o, v};
   endfunction

   task automatic cycle();
      @(posedge clk);
      edge_n++;
      model_edge();
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < 3; k++) rq[k] = 8'hFF;
      repeat (n) cycle();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int k = 0; k < 3; k++) rq[k] = 8'hFF;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if (obs_vec(k) !== exp_vec(k)) begin
            miscompares++;
            $display("FAIL reset inst%0d: got %h expected %h", k, obs_vec(k), exp_vec(k));
         end
      end
      vectors++;
      if (bgrt_a !== 2'b11 || owner_a !== 3'd0 || busy_a !== 1'b0 || ovf_a !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: got bgrt=%b owner=%0d busy=%b ovf=%b expected 11/0/0/0",
                  bgrt_a, owner_a, busy_a, ovf_a);
      end
      reset = 1'b0;
   endtask

   task automatic test_grant_latency();
      rq[0] = 8'hFE;
      cycle();
      vectors++;
      if (bgrt_a !== 2'b10 || owner_a !== 3'd0 || busy_a !== 1'b1) begin
         miscompares++;
         $display("FAIL grant_latency: got bgrt=%b owner=%0d busy=%b expected 10/0/1", bgrt_a, owner_a, busy_a);
      end
      for (int i = 0; i < 4; i++) begin
         cycle();
         vectors++;
         if (obs_vec(0) !== exp_vec(0)) begin
            miscompares++;
            $display("FAIL grant_hold: got %h expected %h", obs_vec(0), exp_vec(0));
         end
      end
      rq[0] = 8'hFD;
      cycle();
      vectors++;
      if (bgrt_a !== 2'b11 || busy_a !== 1'b0) begin
         miscompares++;
         $display("FAIL release: got bgrt=%b busy=%b expected 11/0", bgrt_a, busy_a);
      end
      cycle();
      vectors++;
      if (bgrt_a !== 2'b11) begin
         miscompares++;
         $display("FAIL turnaround: got bgrt=%b expected 11", bgrt_a);
      end
      cycle();
      vectors++;
      if (bgrt_a !== 2'b01 || owner_a !== 3'd1 || busy_a !== 1'b1) begin
         miscompares++;
         $display("FAIL pending_grant: got bgrt=%b owner=%0d busy=%b expected 01/1/1", bgrt_a, owner_a, busy_a);
      end
      rq[0] = 8'hFF;
      cycle();
   endtask

   task automatic test_round_robin();
      int   prev_own;
      int   grants;
      logic prev_busy;
      idle(4);
      prev_own  = -1;
      grants    = 0;
      prev_busy = busy_a;
      rq[0]     = 8'hFC;
      for (int c = 0; c < 30; c++) begin
         cycle();
         vectors++;
         if (obs_vec(0) !== exp_vec(0)) begin
            miscompares++;
            $display("FAIL rr_model edge%0d: got %h expected %h", edge_n, obs_vec(0), exp_vec(0));
         end
         if (busy_a === 1'b1 && prev_busy === 1'b0) begin
            grants++;
            vectors++;
            if (int'(owner_a) == prev_own) begin
               miscompares++;
               $display("FAIL rr_alternate: got owner %0d expected not %0d", owner_a, prev_own);
            end
            prev_own = int'(owner_a);
         end
         prev_busy = busy_a;
         if (m_busy[0] != 0 && (edge_n - m_gedge[0]) >= 2) rq[0] = 8'hFC | (8'h01 << m_own[0]);
         else rq[0] = 8'hFC;
      end
      vectors++;
      if (grants < 5) begin
         miscompares++;
         $display("FAIL rr_grant_count: got %0d expected >= 5", grants);
      end
      rq[0] = 8'hFF;
   endtask

   task automatic test_fixed_priority();
      int   grants;
      logic prev_busy;
      logic found;
      idle(3);
      grants    = 0;
      prev_busy = busy_b;
      rq[1]     = 8'hFC;
      for (int c = 0; c < 20; c++) begin
         cycle();
         vectors++;
         if (obs_vec(1) !== exp_vec(1)) begin
            miscompares++;
            $display("FAIL fp_model edge%0d: got %h expected %h", edge_n, obs_vec(1), exp_vec(1));
         end
         if (busy_b === 1'b1 && prev_busy === 1'b0) begin
            grants++;
            vectors++;
            if (owner_b !== 3'd0) begin
               miscompares++;
               $display("FAIL fp_starve: got owner %0d expected 0", owner_b);
            end
         end
         prev_busy = busy_b;
         if (m_busy[1] != 0 && (edge_n - m_gedge[1]) >= 1) rq[1] = 8'hFD;
         else rq[1] = 8'hFC;
      end
      vectors++;
      if (grants < 4) begin
         miscompares++;
         $display("FAIL fp_grant_count: got %0d expected >= 4", grants);
      end
      rq[1] = 8'hFD;
      found = 1'b0;
      for (int c = 0; c < 6 && !found; c++) begin
         cycle();
         if (busy_b === 1'b1 && owner_b === 3'd1) found = 1'b1;
      end
      vectors++;
      if (!found) begin
         miscompares++;
         $display("FAIL fp_master1_wins: got bgrt=%b owner=%0d expected grant to 1", bgrt_b, owner_b);
      end
      rq[1] = 8'hFF;
      cycle();
   endtask

   task automatic test_turn_zero();
      idle(3);
      rq[1] = 8'hFE;
      cycle();
      vectors++;
      if (bgrt_b !== 2'b10) begin
         miscompares++;
         $display("FAIL tz_grant0: got bgrt=%b expected 10", bgrt_b);
      end
      rq[1] = 8'hFC;
      cycle();
      vectors++;
      if (bgrt_b !== 2'b10) begin
         miscompares++;
         $display("FAIL tz_hold: got bgrt=%b expected 10", bgrt_b);
      end
      rq[1] = 8'hFD;
      cycle();
      vectors++;
      if (bgrt_b !== 2'b11 || busy_b !== 1'b0) begin
         miscompares++;
         $display("FAIL tz_gap: got bgrt=%b busy=%b expected 11/0", bgrt_b, busy_b);
      end
      cycle();
      vectors++;
      if (bgrt_b !== 2'b01 || owner_b !== 3'd1) begin
         miscompares++;
         $display("FAIL tz_grant1: got bgrt=%b owner=%0d expected 01/1", bgrt_b, owner_b);
      end
      rq[1] = 8'hFF;
      cycle();
   endtask

   task automatic test_tenure();
      idle(4);
      rq[0] = 8'hFD;
      cycle();
      vectors++;
      if (bgrt_a !== 2'b01 || ovf_a !== 1'b0) begin
         miscompares++;
         $display("FAIL tenure_grant: got bgrt=%b ovf=%b expected 01/0", bgrt_a, ovf_a);
      end
      for (int h = 1; h <= 10; h++) begin
         cycle();
         vectors++;
         if (bgrt_a !== 2'b01 || ovf_a !== 1'(h >= 4)) begin
            miscompares++;
            $display("FAIL tenure_hold h=%0d: got bgrt=%b ovf=%b expected 01/%0d", h, bgrt_a, ovf_a, (h >= 4));
         end
      end
      rq[0] = 8'hFF;
      cycle();
      vectors++;
      if (bgrt_a !== 2'b11 || ovf_a !== 1'b0) begin
         miscompares++;
         $display("FAIL tenure_release: got bgrt=%b ovf=%b expected 11/0", bgrt_a, ovf_a);
      end
   endtask

   task automatic test_reset_mid();
      idle(4);
      rq[0] = 8'hFE;
      cycle();
      cycle();
      reset = 1'b1;
      model_reset();
      #1;
      vectors++;
      if (bgrt_a !== 2'b11 || busy_a !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset: got bgrt=%b busy=%b expected 11/0", bgrt_a, busy_a);
      end
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if (obs_vec(k) !== exp_vec(k)) begin
            miscompares++;
            $display("FAIL async_reset_all inst%0d: got %h expected %h", k, obs_vec(k), exp_vec(k));
         end
      end
      rq[0] = 8'hFD;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      cycle();
      vectors++;
      if (bgrt_a !== 2'b01 || owner_a !== 3'd1 || busy_a !== 1'b1) begin
         miscompares++;
         $display("FAIL post_reset_grant: got bgrt=%b owner=%0d busy=%b expected 01/1/1", bgrt_a, owner_a, busy_a);
      end
      rq[0] = 8'hFF;
      cycle();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < 3; k++) begin
            logic [7:0] m;
            m = 8'd0;
            for (int b = 0; b < 8; b++) m[b] = ($urandom_range(0, 3) == 0);
            rq[k] = rq[k] ^ m;
         end
         cycle();
         for (int k = 0; k < 3; k++) begin
            vectors++;
            if (obs_vec(k) !== exp_vec(k)) begin
               miscompares++;
               $display("FAIL random inst%0d edge%0d: got %h expected %h", k, edge_n, obs_vec(k), exp_vec(k));
            end
         end
      end
   endtask

   // Scenario sequence and summary.
   initial begin
      vectors     = 0;
      miscompares = 0;
      edge_n      = 0;
      test_reset();
      test_grant_latency();
      test_round_robin();
      test_fixed_priority();
      test_turn_zero();
      test_tenure();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
